// File: rtl/lcd_scan_timing_gen.sv
// lcd_scan_timing_gen: scan/timing generator for a parallel-RGB LCD panel.
// Runs horizontal/vertical counters at clock/CLK_DIV, publishes the current
// (x, y) to the pixel source, and registers colour and sync onto the panel
// pins once per pixel period.
// Optional build macro LCD_TEST_PATTERN_EN adds a test_mode input that
// replaces the colour inputs with 8 vertical colour bars.
module lcd_scan_timing_gen #(
  parameter int unsigned CLK_DIV  = 3,
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FRONT  = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BACK   = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FRONT  = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BACK   = 2
) (
  input  logic       clock,
  input  logic       reset,
`ifdef LCD_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       pixel_tick,
  output logic       frame_start,
  input  logic [4:0] red,
  input  logic [5:0] green,
  input  logic [4:0] blue,
  output logic       lcd_clk,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [4:0] lcd_red,
  output logic [5:0] lcd_green,
  output logic [4:0] lcd_blue
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);

  localparam logic [8:0] V_ACT      = 9'(V_ACTIVE);
  localparam logic [8:0] V_SYNC_BEG = 9'(V_ACTIVE + V_FRONT);
  localparam logic [8:0] V_SYNC_END = 9'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [8:0] V_LAST     = 9'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_next;
  logic [9:0]       h_cnt;
  logic [8:0]       v_cnt;
  logic             h_last;
  logic             v_last;
  logic             active;
  logic             h_in_sync;
  logic             v_in_sync;
  logic [4:0]       pix_red;
  logic [5:0]       pix_green;
  logic [4:0]       pix_blue;

  assign pixel_tick   = (div_cnt == DIV_LAST);
  assign div_cnt_next = pixel_tick ? '0 : div_cnt + 1'b1;

  assign h_last      = (h_cnt == H_LAST);
  assign v_last      = (v_cnt == V_LAST);
  assign frame_start = pixel_tick & h_last & v_last;

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  assign x = active ? h_cnt[8:0] : '0;
  assign y = active ? v_cnt      : '0;

  // Clock divider; lcd_clk is low on the clock the pins update and rises
  // at least one clock later so the panel sees stable data on its edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      lcd_clk <= 1'b0;
    end else begin
      div_cnt <= div_cnt_next;
      lcd_clk <= (div_cnt_next >= DIV_HALF);
    end
  end

  // Horizontal/vertical scan counters, advanced once per pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'(x / 9'd60);

  // Colour source: 60-pixel vertical bars in test mode, else the pixel source.
  always_comb begin
    pix_red   = red;
    pix_green = green;
    pix_blue  = blue;
    if (test_mode) begin
      pix_red   = bar[2] ? 5'd31 : 5'd0;
      pix_green = bar[1] ? 6'd63 : 6'd0;
      pix_blue  = bar[0] ? 5'd31 : 5'd0;
    end
  end
`else
  // Colour source: always the external pixel source.
  always_comb begin
    pix_red   = red;
    pix_green = green;
    pix_blue  = blue;
  end
`endif

  // Pin stage: all panel signals registered together, one pixel behind the counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      lcd_de    <= 1'b0;
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
      lcd_red   <= '0;
      lcd_green <= '0;
      lcd_blue  <= '0;
    end else if (pixel_tick) begin
      lcd_de    <= active;
      lcd_hsync <= ~h_in_sync;
      lcd_vsync <= ~v_in_sync;
      lcd_red   <= active ? pix_red   : '0;
      lcd_green <= active ? pix_green : '0;
      lcd_blue  <= active ? pix_blue  : '0;
    end
  end

endmodule
